// File: rtl/useq_if.sv
// Sequencer bundle: microword sequencing inputs and uPC/trap status outputs.
interface useq_if #(
    parameter int AW    = 9,
    parameter int DEPTH = 4
);
    localparam int SW = $clog2(DEPTH) + 1;

    logic          stall;
    logic [2:0]    seq_op;
    logic [AW-1:0] target;
    logic          cond;
    logic [AW-1:0] dispatch_addr;
    logic          irq;
    logic          exc;
    logic [AW-1:0] upc;
    logic          trap_taken;
    logic          in_irq;
    logic          stk_err;
    logic [SW-1:0] sp;

    modport master (
        output stall, seq_op, target, cond, dispatch_addr, irq, exc,
        input  upc, trap_taken, in_irq, stk_err, sp
    );

    modport slave (
        input  stall, seq_op, target, cond, dispatch_addr, irq, exc,
        output upc, trap_taken, in_irq, stk_err, sp
    );
endinterface

// File: rtl/useq_ctrl.sv
// Microcode sequencer: next-uPC select, return stack, loop counter, traps.
// Optional perf counters (stall_cycles, trap_count) under USEQ_PERF_CNT_EN.
module useq_ctrl #(
    parameter int            AW      = 9,
    parameter int            DEPTH   = 4,
    parameter logic [AW-1:0] IRQ_VEC = 9'h01F,
    parameter logic [AW-1:0] EXC_VEC = 9'h01D,
    parameter logic [AW-1:0] RST_VEC = 9'h000
) (
    input  logic        clk,
    input  logic        rst,
    useq_if.slave       bus
`ifdef USEQ_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [7:0]  trap_count
`endif
);
    localparam int SW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NEXT, OP_JUMP, OP_BR, OP_DISP,
        OP_CALL, OP_RET, OP_LOOP, OP_LDCNT
    } op_e;

    logic [AW-1:0] upc_q, upc_d, upc_inc, seq_nxt, top, push_val;
    logic [SW-1:0] sp_q, sp_d, saved_q, saved_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          in_irq_q, in_irq_d, err_q, err_d, trap_q, trap_d;
    logic          push, full, empty;
    logic [AW-1:0] stk [DEPTH];
    op_e           op;

    always_comb begin
        op       = op_e'(bus.seq_op);
        upc_inc  = upc_q + 1'b1;
        top      = stk[IW'(sp_q - 1'b1)];
        full     = (sp_q == SW'(DEPTH));
        empty    = (sp_q == '0);
        upc_d    = upc_q;
        sp_d     = sp_q;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        in_irq_d = in_irq_q;
        err_d    = err_q;
        trap_d   = 1'b0;
        push     = 1'b0;
        push_val = upc_inc;

        // Address the microword would have sequenced to, ignoring side effects
        unique case (op)
            OP_JUMP, OP_CALL: seq_nxt = bus.target;
            OP_BR:   seq_nxt = bus.cond ? bus.target : upc_inc;
            OP_DISP: seq_nxt = bus.dispatch_addr;
            OP_RET:  seq_nxt = empty ? EXC_VEC : top;
            OP_LOOP: seq_nxt = (cnt_q != 8'd0) ? bus.target : upc_inc;
            default: seq_nxt = upc_inc;
        endcase

        if (bus.exc) begin
            push     = 1'b1;
            push_val = bus.stall ? upc_q : seq_nxt;
            upc_d    = EXC_VEC;
            trap_d   = 1'b1;
        end else if (bus.irq && !in_irq_q && !bus.stall && op == OP_DISP) begin
            push     = 1'b1;
            push_val = bus.dispatch_addr;
            saved_d  = sp_q;
            in_irq_d = 1'b1;
            upc_d    = IRQ_VEC;
            trap_d   = 1'b1;
        end else if (!bus.stall) begin
            unique case (op)
                OP_CALL: begin
                    push  = 1'b1;
                    upc_d = bus.target;
                end
                OP_RET: begin
                    if (empty) begin
                        err_d  = 1'b1;
                        upc_d  = EXC_VEC;
                        trap_d = 1'b1;
                    end else begin
                        upc_d = top;
                        sp_d  = sp_q - 1'b1;
                        if (in_irq_q && sp_d == saved_q)
                            in_irq_d = 1'b0;
                    end
                end
                OP_LOOP: begin
                    upc_d = seq_nxt;
                    if (cnt_q != 8'd0)
                        cnt_d = cnt_q - 1'b1;
                end
                OP_LDCNT: begin
                    cnt_d = bus.target[7:0];
                    upc_d = upc_inc;
                end
                default: upc_d = seq_nxt;
            endcase
        end

        // A full stack drops the push but the jump still happens
        if (push) begin
            if (full)
                err_d = 1'b1;
            else
                sp_d = sp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q    <= RST_VEC;
            sp_q     <= '0;
            saved_q  <= '0;
            cnt_q    <= '0;
            in_irq_q <= 1'b0;
            err_q    <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            upc_q    <= upc_d;
            sp_q     <= sp_d;
            saved_q  <= saved_d;
            cnt_q    <= cnt_d;
            in_irq_q <= in_irq_d;
            err_q    <= err_d;
            trap_q   <= trap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full)
            stk[sp_q[IW-1:0]] <= push_val;
    end

`ifdef USEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            trap_count   <= '0;
        end else begin
            if (bus.stall && !bus.exc && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (trap_d && trap_count != '1)
                trap_count <= trap_count + 1'b1;
        end
    end
`endif

    assign bus.upc        = upc_q;
    assign bus.sp         = sp_q;
    assign bus.trap_taken = trap_q;
    assign bus.in_irq     = in_irq_q;
    assign bus.stk_err    = err_q;
endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: directed scenarios then random cycles vs a queue-based model.
module tb_useq_ctrl;
    localparam int AW    = 9;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    useq_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
`ifdef USEQ_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [7:0]  trap_count;
`endif

    useq_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef USEQ_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .trap_count(trap_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] m_upc;
    logic [8:0] m_stk[$];
    logic [7:0] m_cnt;
    int         m_saved;
    bit         m_in_irq, m_err, m_trap;
    int         m_stalls, m_traps;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_push(input logic [8:0] v);
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back(v);
    endfunction

    function automatic void model(input bit r, input bit st,
                                  input logic [2:0] op, input logic [8:0] tg,
                                  input bit c, input logic [8:0] da,
                                  input bit i, input bit e);
        logic [8:0] nx;
        logic [8:0] inc;
        if (r) begin
            m_upc = 9'h000; m_stk.delete(); m_cnt = 0; m_saved = 0;
            m_in_irq = 0; m_err = 0; m_trap = 0;
            m_stalls = 0; m_traps = 0;
            return;
        end
        m_trap = 0;
        inc = m_upc + 9'd1;
        case (op)
            3'd1, 3'd4: nx = tg;
            3'd2: nx = c ? tg : inc;
            3'd3: nx = da;
            3'd5: nx = (m_stk.size() > 0) ? m_stk[$] : 9'h01D;
            3'd6: nx = (m_cnt != 0) ? tg : inc;
            default: nx = inc;
        endcase
        if (e) begin
            m_push(st ? m_upc : nx);
            m_upc = 9'h01D; m_trap = 1;
        end else if (i && !m_in_irq && !st && op == 3'd3) begin
            m_saved = m_stk.size();
            m_push(da);
            m_upc = 9'h01F; m_in_irq = 1; m_trap = 1;
        end else if (st) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            case (op)
                3'd4: begin m_push(inc); m_upc = tg; end
                3'd5: begin
                    if (m_stk.size() == 0) begin
                        m_err = 1; m_upc = 9'h01D; m_trap = 1;
                    end else begin
                        m_upc = m_stk.pop_back();
                        if (m_in_irq && m_stk.size() == m_saved) m_in_irq = 0;
                    end
                end
                3'd6: begin
                    if (m_cnt != 0) m_cnt--;
                    m_upc = nx;
                end
                3'd7: begin m_cnt = tg[7:0]; m_upc = inc; end
                default: m_upc = nx;
            endcase
        end
        if (m_trap && m_traps < 255) m_traps++;
    endfunction

    task automatic cyc(input bit r, input bit st, input logic [2:0] op,
                       input logic [8:0] tg, input bit c,
                       input logic [8:0] da, input bit i, input bit e);
        rst = r;
        bus.stall = st; bus.seq_op = op; bus.target = tg; bus.cond = c;
        bus.dispatch_addr = da; bus.irq = i; bus.exc = e;
        model(r, st, op, tg, c, da, i, e);
        @(posedge clk);
        #1;
        chk("upc", 32'(bus.upc), 32'(m_upc));
        chk("sp", 32'(bus.sp), 32'(m_stk.size()));
        chk("trap_taken", 32'(bus.trap_taken), 32'(m_trap));
        chk("in_irq", 32'(bus.in_irq), 32'(m_in_irq));
        chk("stk_err", 32'(bus.stk_err), 32'(m_err));
`ifdef USEQ_PERF_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        chk("trap_count", 32'(trap_count), 32'(m_traps));
`endif
    endtask

    task automatic op1(input logic [2:0] op, input logic [8:0] tg);
        cyc(0, 0, op, tg, 0, 9'h000, 0, 0);
    endtask

    task automatic reset1();
        cyc(1, 0, 3'd0, 9'h000, 0, 9'h000, 0, 0);
    endtask

    initial begin
        reset1();
        chk("reset_upc", 32'(bus.upc), 32'h000);
        chk("reset_sp", 32'(bus.sp), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            op1(3'd0, 9'h000);
            chk("next_seq", 32'(bus.upc), 32'(k));
        end
        op1(3'd1, 9'h1FF);
        op1(3'd0, 9'h000);
        chk("wrap", 32'(bus.upc), 32'h000);

        cyc(0, 0, 3'd2, 9'h040, 1, 9'h000, 0, 0);
        chk("br_taken", 32'(bus.upc), 32'h040);
        cyc(0, 0, 3'd2, 9'h040, 0, 9'h000, 0, 0);
        chk("br_not", 32'(bus.upc), 32'h041);
        cyc(0, 0, 3'd3, 9'h000, 0, 9'h120, 0, 0);
        chk("disp", 32'(bus.upc), 32'h120);

        op1(3'd1, 9'h010);
        op1(3'd4, 9'h080);
        chk("call_upc", 32'(bus.upc), 32'h080);
        chk("call_sp", 32'(bus.sp), 32'h1);
        op1(3'd5, 9'h000);
        chk("ret_upc", 32'(bus.upc), 32'h011);
        chk("ret_sp", 32'(bus.sp), 32'h0);
        for (int k = 0; k < 5; k++) op1(3'd4, 9'h080);
        chk("ovf_sp", 32'(bus.sp), 32'h4);
        chk("ovf_err", 32'(bus.stk_err), 32'h1);

        reset1();
        op1(3'd5, 9'h000);
        chk("unf_upc", 32'(bus.upc), 32'h01D);
        chk("unf_trap", 32'(bus.trap_taken), 32'h1);
        op1(3'd0, 9'h000);
        chk("trap_pulse", 32'(bus.trap_taken), 32'h0);
        reset1();

        op1(3'd1, 9'h020);
        op1(3'd7, 9'h003);
        for (int k = 0; k < 3; k++) begin
            op1(3'd6, 9'h030);
            chk("loop_taken", 32'(bus.upc), 32'h030);
            op1(3'd1, 9'h021);
        end
        op1(3'd6, 9'h030);
        chk("loop_exit", 32'(bus.upc), 32'h022);

        cyc(0, 0, 3'd0, 9'h000, 0, 9'h100, 1, 0);
        chk("irq_ignored", 32'(bus.in_irq), 32'h0);
        cyc(0, 0, 3'd3, 9'h000, 0, 9'h100, 1, 0);
        chk("irq_upc", 32'(bus.upc), 32'h01F);
        chk("irq_in", 32'(bus.in_irq), 32'h1);
        chk("irq_trap", 32'(bus.trap_taken), 32'h1);
        cyc(0, 0, 3'd0, 9'h000, 0, 9'h100, 1, 0);
        cyc(0, 0, 3'd5, 9'h000, 0, 9'h100, 1, 0);
        chk("irq_ret", 32'(bus.upc), 32'h100);
        chk("irq_clear", 32'(bus.in_irq), 32'h0);

        op1(3'd1, 9'h050);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 3'd0, 9'h000, 0, 9'h000, 0, 0);
            chk("stall_hold", 32'(bus.upc), 32'h050);
        end
        cyc(0, 1, 3'd0, 9'h000, 0, 9'h000, 0, 1);
        chk("exc_stall", 32'(bus.upc), 32'h01D);
        chk("exc_sp", 32'(bus.sp), 32'h1);
        op1(3'd5, 9'h000);
        chk("exc_top", 32'(bus.upc), 32'h050);
        cyc(0, 0, 3'd3, 9'h000, 0, 9'h100, 1, 1);
        chk("exc_wins", 32'(bus.upc), 32'h01D);
        chk("exc_wins_irq", 32'(bus.in_irq), 32'h0);

        for (int n = 0; n < 600; n++) begin
            logic [2:0] op;
            logic [8:0] tg;
            op = 3'($urandom_range(0, 7));
            tg = 9'($urandom_range(0, 511));
            if (op == 3'd7) tg = 9'($urandom_range(0, 5));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, op, tg,
                1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microcode sequencer that computes the 9-bit control-store address (uPC) every cycle and feeds the control-ROM address register.
- Selects among sequential, jump, conditional branch, opcode dispatch, subroutine call/return, loop and trap-vector sources.
- Drives trap entry to the fixed vectors 0x1F (interrupt) and 0x1D (exception).
- Sits between the control ROM's sequencing field and the ROM address register, with stall and trap inputs from the pipeline.

Parameters:
AW, 9, uPC / control-store address width
DEPTH, 4, return-address stack entries (power of 2, >= 2)
IRQ_VEC, 9'h01F, interrupt entry vector
EXC_VEC, 9'h01D, exception / stack-fault entry vector
RST_VEC, 9'h000, reset entry address

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high; the block has one clock, clk
stall  in  1  hold uPC (memory/pipeline wait)
seq_op  in  3  sequencing field of current microword
target  in  AW  branch/jump/call target or loop-count literal
cond  in  1  branch condition for current microword
dispatch_addr  in  AW  opcode-decoded entry address
irq  in  1  level interrupt request
exc  in  1  single-cycle exception pulse
upc  out  AW  registered control-store address
trap_taken  out  1  one-cycle pulse on a cycle where a trap vector is loaded
in_irq  out  1  interrupt handler active (further irq masked)
stk_err  out  1  sticky stack overflow/underflow flag
sp  out  $clog2(DEPTH)+1  current stack depth

Behaviour:
- Reset (rst=1 at posedge): upc=RST_VEC, sp=0, loop_cnt=0, in_irq=0, stk_err=0, trap_taken=0. Reset mid-operation discards stack contents and any pending op.
- All outputs are registered; the next upc is visible one cycle after the controlling inputs are sampled.
- seq_op encoding, applied when no trap and stall=0:
  - 000 NEXT: upc+1
  - 001 JUMP: target
  - 010 BR: target if cond, else upc+1
  - 011 DISP: dispatch_addr; this is the instruction boundary
  - 100 CALL: push upc+1, then target
  - 101 RET: pop into upc
  - 110 LOOP: if loop_cnt!=0, decrement and go to target; else upc+1
  - 111 LDCNT: loop_cnt<=target[7:0], then upc+1
- Arithmetic: upc+1 is modulo 2^AW, so 0x1FF -> 0x000 with no flag. loop_cnt is 8 bits.
- Priority, highest first: rst > exc > irq > stall > seq_op.
- exc=1: the exception trap is taken even when stall=1.
  - Pushes the would-be next address (upc itself if stalled), upc=EXC_VEC, trap_taken=1.
- irq: taken only when irq=1, in_irq=0, stall=0 and seq_op=DISP.
  - Pushes dispatch_addr, upc=IRQ_VEC, in_irq=1, saved_sp<=sp (pre-push value), trap_taken=1.
- in_irq clears when a RET leaves sp==saved_sp.
- stall=1 and no exc: upc, sp and loop_cnt hold; trap_taken=0.
- Push with sp==DEPTH (CALL or trap): stk_err<=1, push dropped, sp unchanged, jump still performed.
- RET with sp==0: stk_err<=1, upc=EXC_VEC, trap_taken=1, no push.
- stk_err clears only on rst.
- Stack is LIFO. Push writes entry[sp] and increments sp; pop reads entry[sp-1] and decrements sp.
- Simultaneous exc and irq: exc wins, irq stays pending (level) and is re-evaluated at the next DISP.

Optional Feature:
- Macro USEQ_PERF_CNT_EN.
- When defined: adds outputs stall_cycles[15:0] and trap_count[7:0].
  - stall_cycles increments on each stall=1 cycle with no exc.
  - trap_count increments on each trap_taken.
  - Both saturate at all-ones and reset to 0 on rst.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- rst=1, then seq_op=NEXT for 3 cycles -> upc 0x000,0x001,0x002,0x003; run from upc=0x1FF with NEXT -> 0x000.
- BR target=0x040: cond=1 -> upc=0x040; cond=0 at upc=0x040 -> 0x041. DISP with dispatch_addr=0x120 -> 0x120.
- From upc=0x010: CALL 0x080 then RET -> upc 0x080, sp=1, then 0x011, sp=0. Five nested CALLs with DEPTH=4 -> stk_err=1, sp=4. RET at sp=0 -> upc=0x1D, trap_taken=1.
- LDCNT target=3 at 0x020, then LOOP target=0x030 at 0x021 -> branches to 0x030 three times, then falls to 0x022.
- irq=1 with seq_op=NEXT -> ignored; irq=1 on DISP dispatch_addr=0x100 -> upc=0x1F, in_irq=1, trap_taken=1; handler RET -> upc=0x100, in_irq=0.
- stall=1 for 4 cycles at upc=0x050 -> upc holds 0x050; exc=1 during stall -> upc=0x1D next cycle, stack top=0x050; exc and irq together -> EXC_VEC taken.
